// File: rtl/hbm_ss_health_mon.sv
// -----------------------------------------------------------------------------
// hbm_ss_health_mon
//
// Per-device health monitor and bring-up sequencer for a multi-stack HBM
// subsystem. Each device runs an independent FSM:
//   RST -> WAIT_CAL -> READY / FAIL, with TRIP as a terminal state.
// The FSM tracks the calibration result, a calibration timeout, a debounced
// catastrophic-temperature trip and the temperature warning level. The
// per-device READY state releases the AXI-MM channel resets for that device's
// channel group toward the AFU.
//
// Ports:
//   clk            - single clock, all logic on its rising edge
//   reset          - synchronous, active-high reset
//   cal_success    - per-device calibration success level
//   cal_fail       - per-device calibration fail level
//   cattrip        - per-device catastrophic temperature level
//   temp           - per-device 3-bit temperature code, device d at [3d+2:3d]
//   retry          - per-device pulse, restarts calibration wait from FAIL
//   sticky_clr     - per-device pulse, clears sticky bits and peak temperature
//   dev_ready      - device is in READY
//   ch_rst_n       - active-low channel reset, one group per device
//   dev_state      - encoded FSM state per device (RST=0 .. TRIP=4)
//   sticky_status  - per device {trip, temp_warn, cal_timeout, cal_fail}
//   temp_max       - peak temperature code since reset or last sticky_clr
//   irq            - one-cycle pulse on any sticky bit rising
// -----------------------------------------------------------------------------
module hbm_ss_health_mon #(
   parameter int         NUM_DEVICES        = 2,
   parameter int         NUM_CHANNELS       = 32,
   parameter int         CAL_TIMEOUT_CYCLES = 1048576,
   parameter int         DEBOUNCE_CYCLES    = 16,
   parameter logic [2:0] TEMP_WARN          = 3'd5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_DEVICES-1:0]    cal_success,
   input  logic [NUM_DEVICES-1:0]    cal_fail,
   input  logic [NUM_DEVICES-1:0]    cattrip,
   input  logic [3*NUM_DEVICES-1:0]  temp,
   input  logic [NUM_DEVICES-1:0]    retry,
   input  logic [NUM_DEVICES-1:0]    sticky_clr,
   output logic [NUM_DEVICES-1:0]    dev_ready,
   output logic [NUM_CHANNELS-1:0]   ch_rst_n,
   output logic [3*NUM_DEVICES-1:0]  dev_state,
   output logic [4*NUM_DEVICES-1:0]  sticky_status,
   output logic [3*NUM_DEVICES-1:0]  temp_max,
   output logic                      irq
);

   localparam int CH_PER_DEV = NUM_CHANNELS / NUM_DEVICES;
   localparam int TW         = $clog2(CAL_TIMEOUT_CYCLES);
   localparam int DW         = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [TW-1:0] TMO_LAST = TW'(CAL_TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);

   typedef enum logic [2:0] {
      ST_RST      = 3'd0,
      ST_WAIT_CAL = 3'd1,
      ST_READY    = 3'd2,
      ST_FAIL     = 3'd3,
      ST_TRIP     = 3'd4
   } state_t;

   // Per-device "some sticky bit rises this cycle" flags, merged into irq.
   logic [NUM_DEVICES-1:0] rise_vec;
   logic                   irq_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_dev
         state_t          state_q, state_d;
         logic [TW-1:0]   timer_q, timer_d;
         logic [DW-1:0]   deb_q, deb_d;
         logic [3:0]      sticky_q, sticky_d, set_v;
         logic [2:0]      temp_max_q, temp_max_d;
         logic [2:0]      temp_v;
         logic            ready_q;

         assign temp_v = temp[3*gi +: 3];

         always_comb begin
            state_d = state_q;
            set_v   = 4'b0000;
            // Timer only runs in WAIT_CAL; any entry into WAIT_CAL starts at 0.
            timer_d = (state_q == ST_WAIT_CAL) ? timer_q + 1'b1 : '0;
            // Debounce counter saturates so a long cattrip cannot wrap.
            if (cattrip[gi]) begin
               deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
            end else begin
               deb_d = '0;
            end

            case (state_q)
               ST_RST: begin
                  state_d = ST_WAIT_CAL;
               end
               ST_WAIT_CAL: begin
                  // cal_fail wins over cal_success when both are high.
                  if (cal_fail[gi]) begin
                     state_d  = ST_FAIL;
                     set_v[0] = 1'b1;
                  end else if (cal_success[gi]) begin
                     state_d = ST_READY;
                  end else if (timer_q == TMO_LAST) begin
                     state_d  = ST_FAIL;
                     set_v[1] = 1'b1;
                  end
               end
               ST_READY: begin
                  if (cal_fail[gi] || !cal_success[gi]) begin
                     state_d  = ST_FAIL;
                     set_v[0] = 1'b1;
                  end
               end
               ST_FAIL: begin
                  if (retry[gi]) begin
                     state_d = ST_WAIT_CAL;
                  end
               end
               ST_TRIP: begin
                  state_d = ST_TRIP;
               end
               default: begin
                  state_d = ST_RST;
               end
            endcase

            // A debounced trip overrides whatever transition was chosen above,
            // including the calibration sticky sets that went with it.
            if ((state_q != ST_RST) && (state_q != ST_TRIP) && (deb_d == DEB_MAX)) begin
               state_d    = ST_TRIP;
               set_v[1:0] = 2'b00;
               set_v[3]   = 1'b1;
            end

            if ((state_q != ST_RST) && (temp_v >= TEMP_WARN)) begin
               set_v[2] = 1'b1;
            end

            // Set beats clear in the same cycle.
            sticky_d = (sticky_clr[gi] ? 4'b0000 : sticky_q) | set_v;

            if (sticky_clr[gi]) begin
               temp_max_d = temp_v;
            end else if (temp_v > temp_max_q) begin
               temp_max_d = temp_v;
            end else begin
               temp_max_d = temp_max_q;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q    <= ST_RST;
               timer_q    <= '0;
               deb_q      <= '0;
               sticky_q   <= 4'b0000;
               temp_max_q <= 3'd0;
               ready_q    <= 1'b0;
            end else begin
               state_q    <= state_d;
               timer_q    <= timer_d;
               deb_q      <= deb_d;
               sticky_q   <= sticky_d;
               temp_max_q <= temp_max_d;
               // Taken from the next state so ready and channel resets move
               // on the same edge as dev_state.
               ready_q    <= (state_d == ST_READY);
            end
         end

         assign rise_vec[gi]                           = |(sticky_d & ~sticky_q);
         assign dev_ready[gi]                          = ready_q;
         assign dev_state[3*gi +: 3]                   = state_q;
         assign sticky_status[4*gi +: 4]               = sticky_q;
         assign temp_max[3*gi +: 3]                    = temp_max_q;
         assign ch_rst_n[gi*CH_PER_DEV +: CH_PER_DEV]  = {CH_PER_DEV{ready_q}};
      end
   endgenerate

   // irq is high in the cycle in which the new sticky value is first visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |rise_vec;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_hbm_ss_health_mon.sv
module tb_hbm_ss_health_mon;

   logic       clk;
   logic       reset;
   logic [1:0] cal_success;
   logic [1:0] cal_fail;
   logic [1:0] cattrip;
   logic [5:0] temp;
   logic [1:0] retry;
   logic [1:0] sticky_clr;
   logic [1:0] dev_ready;
   logic [3:0] ch_rst_n;
   logic [5:0] dev_state;
   logic [7:0] sticky_status;
   logic [5:0] temp_max;
   logic       irq;

   int checks;
   int failures;

   hbm_ss_health_mon #(
      .NUM_DEVICES        (2),
      .NUM_CHANNELS       (4),
      .CAL_TIMEOUT_CYCLES (8),
      .DEBOUNCE_CYCLES    (4),
      .TEMP_WARN          (3'd5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cal_success   (cal_success),
      .cal_fail      (cal_fail),
      .cattrip       (cattrip),
      .temp          (temp),
      .retry         (retry),
      .sticky_clr    (sticky_clr),
      .dev_ready     (dev_ready),
      .ch_rst_n      (ch_rst_n),
      .dev_state     (dev_state),
      .sticky_status (sticky_status),
      .temp_max      (temp_max),
      .irq           (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      checks++; if (dev_state !== 6'd0) begin failures++; $display("FAIL reset_state got=%h exp=%h", dev_state, 6'd0); end
      checks++; if (dev_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=%b", dev_ready, 2'b00); end
      checks++; if (ch_rst_n !== 4'b0000) begin failures++; $display("FAIL reset_ch_rst_n got=%b exp=%b", ch_rst_n, 4'b0000); end
      checks++; if (sticky_status !== 8'h00) begin failures++; $display("FAIL reset_sticky got=%h exp=%h", sticky_status, 8'h00); end
      checks++; if (temp_max !== 6'd0) begin failures++; $display("FAIL reset_temp_max got=%h exp=%h", temp_max, 6'd0); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=%b", irq, 1'b0); end
      reset = 1'b0;
      tick();
      checks++; if (dev_state !== {3'd1, 3'd1}) begin failures++; $display("FAIL release_state got=%h exp=%h", dev_state, {3'd1, 3'd1}); end
      checks++; if (ch_rst_n !== 4'b0000) begin failures++; $display("FAIL release_ch_rst_n got=%b exp=%b", ch_rst_n, 4'b0000); end
      $display("txn reset: state=%h ready=%b ch_rst_n=%b", dev_state, dev_ready, ch_rst_n);
   endtask

   task automatic test_ready();
      repeat (3) tick();
      cal_success[0] = 1'b1;
      tick();
      checks++; if (dev_state !== {3'd1, 3'd2}) begin failures++; $display("FAIL ready_state got=%h exp=%h", dev_state, {3'd1, 3'd2}); end
      checks++; if (dev_ready !== 2'b01) begin failures++; $display("FAIL ready_dev_ready got=%b exp=%b", dev_ready, 2'b01); end
      checks++; if (ch_rst_n !== 4'b0011) begin failures++; $display("FAIL ready_ch_rst_n got=%b exp=%b", ch_rst_n, 4'b0011); end
      $display("txn ready: state=%h ready=%b ch_rst_n=%b", dev_state, dev_ready, ch_rst_n);
   endtask

   // Device 1 entered WAIT_CAL at release; it has now seen 4 cycles.
   task automatic test_timeout();
      repeat (3) tick();
      checks++; if (dev_state[5:3] !== 3'd1) begin failures++; $display("FAIL tmo_before got=%0d exp=%0d", dev_state[5:3], 1); end
      tick();
      checks++; if (dev_state[5:3] !== 3'd3) begin failures++; $display("FAIL tmo_state got=%0d exp=%0d", dev_state[5:3], 3); end
      checks++; if (sticky_status[7:4] !== 4'b0010) begin failures++; $display("FAIL tmo_sticky got=%b exp=%b", sticky_status[7:4], 4'b0010); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL tmo_irq got=%b exp=%b", irq, 1'b1); end
      tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tmo_irq_pulse got=%b exp=%b", irq, 1'b0); end
      retry[1] = 1'b1;
      tick();
      retry[1] = 1'b0;
      checks++; if (dev_state[5:3] !== 3'd1) begin failures++; $display("FAIL retry_state got=%0d exp=%0d", dev_state[5:3], 1); end
      repeat (7) tick();
      checks++; if (dev_state[5:3] !== 3'd1) begin failures++; $display("FAIL tmo2_before got=%0d exp=%0d", dev_state[5:3], 1); end
      tick();
      checks++; if (dev_state[5:3] !== 3'd3) begin failures++; $display("FAIL tmo2_state got=%0d exp=%0d", dev_state[5:3], 3); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tmo2_irq got=%b exp=%b", irq, 1'b0); end
      checks++; if (sticky_status[7:4] !== 4'b0010) begin failures++; $display("FAIL tmo2_sticky got=%b exp=%b", sticky_status[7:4], 4'b0010); end
      checks++; if (ch_rst_n !== 4'b0011) begin failures++; $display("FAIL tmo2_ch_rst_n got=%b exp=%b", ch_rst_n, 4'b0011); end
      $display("txn timeout: state=%h sticky=%h irq=%b", dev_state, sticky_status, irq);
   endtask

   task automatic test_debounce();
      cattrip[0] = 1'b1;
      repeat (3) tick();
      cattrip[0] = 1'b0;
      tick();
      checks++; if (dev_state[2:0] !== 3'd2) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dev_state[2:0], 2); end
      checks++; if (sticky_status[3:0] !== 4'b0000) begin failures++; $display("FAIL glitch_sticky got=%b exp=%b", sticky_status[3:0], 4'b0000); end
      cattrip[0] = 1'b1;
      repeat (3) tick();
      checks++; if (dev_state[2:0] !== 3'd2) begin failures++; $display("FAIL deb3_state got=%0d exp=%0d", dev_state[2:0], 2); end
      tick();
      checks++; if (dev_state[2:0] !== 3'd4) begin failures++; $display("FAIL trip_state got=%0d exp=%0d", dev_state[2:0], 4); end
      checks++; if (ch_rst_n !== 4'b0000) begin failures++; $display("FAIL trip_ch_rst_n got=%b exp=%b", ch_rst_n, 4'b0000); end
      checks++; if (dev_ready !== 2'b00) begin failures++; $display("FAIL trip_ready got=%b exp=%b", dev_ready, 2'b00); end
      checks++; if (sticky_status[3:0] !== 4'b1000) begin failures++; $display("FAIL trip_sticky got=%b exp=%b", sticky_status[3:0], 4'b1000); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL trip_irq got=%b exp=%b", irq, 1'b1); end
      cattrip[0] = 1'b0;
      retry[0]   = 1'b1;
      tick();
      retry[0]   = 1'b0;
      checks++; if (dev_state[2:0] !== 3'd4) begin failures++; $display("FAIL trip_hold got=%0d exp=%0d", dev_state[2:0], 4); end
      $display("txn debounce: state=%h sticky=%h ch_rst_n=%b", dev_state, sticky_status, ch_rst_n);
   endtask

   task automatic test_both_cal();
      retry[1] = 1'b1;
      tick();
      retry[1] = 1'b0;
      checks++; if (dev_state[5:3] !== 3'd1) begin failures++; $display("FAIL both_retry got=%0d exp=%0d", dev_state[5:3], 1); end
      cal_success[1] = 1'b1;
      cal_fail[1]    = 1'b1;
      tick();
      cal_success[1] = 1'b0;
      cal_fail[1]    = 1'b0;
      checks++; if (dev_state[5:3] !== 3'd3) begin failures++; $display("FAIL both_state got=%0d exp=%0d", dev_state[5:3], 3); end
      checks++; if (sticky_status[7:4] !== 4'b0011) begin failures++; $display("FAIL both_sticky got=%b exp=%b", sticky_status[7:4], 4'b0011); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL both_irq got=%b exp=%b", irq, 1'b1); end
      tick();
      temp[5:3]     = 3'd6;
      sticky_clr[1] = 1'b1;
      tick();
      sticky_clr[1] = 1'b0;
      checks++; if (sticky_status[7:4] !== 4'b0100) begin failures++; $display("FAIL clrset_sticky got=%b exp=%b", sticky_status[7:4], 4'b0100); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clrset_irq got=%b exp=%b", irq, 1'b1); end
      checks++; if (temp_max[5:3] !== 3'd6) begin failures++; $display("FAIL clrset_temp_max got=%0d exp=%0d", temp_max[5:3], 6); end
      temp[5:3] = 3'd0;
      tick();
      $display("txn both_cal: state=%h sticky=%h temp_max=%h", dev_state, sticky_status, temp_max);
   endtask

   task automatic test_temp();
      temp[2:0] = 3'd2;
      tick();
      checks++; if (temp_max[2:0] !== 3'd2) begin failures++; $display("FAIL temp2_max got=%0d exp=%0d", temp_max[2:0], 2); end
      checks++; if (sticky_status[3:0] !== 4'b1000) begin failures++; $display("FAIL temp2_sticky got=%b exp=%b", sticky_status[3:0], 4'b1000); end
      temp[2:0] = 3'd6;
      tick();
      checks++; if (temp_max[2:0] !== 3'd6) begin failures++; $display("FAIL temp6_max got=%0d exp=%0d", temp_max[2:0], 6); end
      checks++; if (sticky_status[3:0] !== 4'b1100) begin failures++; $display("FAIL temp6_sticky got=%b exp=%b", sticky_status[3:0], 4'b1100); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL temp6_irq got=%b exp=%b", irq, 1'b1); end
      temp[2:0] = 3'd3;
      tick();
      checks++; if (temp_max[2:0] !== 3'd6) begin failures++; $display("FAIL temp3_max got=%0d exp=%0d", temp_max[2:0], 6); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL temp3_irq got=%b exp=%b", irq, 1'b0); end
      sticky_clr[0] = 1'b1;
      tick();
      sticky_clr[0] = 1'b0;
      checks++; if (temp_max[2:0] !== 3'd3) begin failures++; $display("FAIL clr_temp_max got=%0d exp=%0d", temp_max[2:0], 3); end
      checks++; if (sticky_status[3:0] !== 4'b0000) begin failures++; $display("FAIL clr_sticky got=%b exp=%b", sticky_status[3:0], 4'b0000); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq got=%b exp=%b", irq, 1'b0); end
      checks++; if (sticky_status[7:4] !== 4'b0100) begin failures++; $display("FAIL clr_other_dev got=%b exp=%b", sticky_status[7:4], 4'b0100); end
      $display("txn temp: temp_max=%h sticky=%h irq=%b", temp_max, sticky_status, irq);
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      reset       = 1'b0;
      cal_success = 2'b01;
      cal_fail    = 2'b00;
      cattrip     = 2'b10;
      temp        = {3'd7, 3'd4};
      tick();
      checks++; if (dev_state !== {3'd1, 3'd1}) begin failures++; $display("FAIL mid_enter got=%h exp=%h", dev_state, {3'd1, 3'd1}); end
      repeat (3) tick();
      checks++; if (dev_state !== {3'd4, 3'd2}) begin failures++; $display("FAIL mid_setup got=%h exp=%h", dev_state, {3'd4, 3'd2}); end
      reset = 1'b1;
      tick();
      checks++; if (dev_state !== 6'd0) begin failures++; $display("FAIL mid_state got=%h exp=%h", dev_state, 6'd0); end
      checks++; if (dev_ready !== 2'b00) begin failures++; $display("FAIL mid_ready got=%b exp=%b", dev_ready, 2'b00); end
      checks++; if (ch_rst_n !== 4'b0000) begin failures++; $display("FAIL mid_ch_rst_n got=%b exp=%b", ch_rst_n, 4'b0000); end
      checks++; if (sticky_status !== 8'h00) begin failures++; $display("FAIL mid_sticky got=%h exp=%h", sticky_status, 8'h00); end
      checks++; if (temp_max !== 6'd0) begin failures++; $display("FAIL mid_temp_max got=%h exp=%h", temp_max, 6'd0); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%b exp=%b", irq, 1'b0); end
      reset       = 1'b0;
      cattrip     = 2'b00;
      cal_success = 2'b00;
      temp        = 6'd0;
      tick();
      checks++; if (dev_state !== {3'd1, 3'd1}) begin failures++; $display("FAIL mid_reenter got=%h exp=%h", dev_state, {3'd1, 3'd1}); end
      $display("txn reset_mid: state=%h sticky=%h", dev_state, sticky_status);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      cal_success = 2'b00;
      cal_fail    = 2'b00;
      cattrip     = 2'b00;
      temp        = 6'd0;
      retry       = 2'b00;
      sticky_clr  = 2'b00;
      test_reset();
      test_ready();
      test_timeout();
      test_debounce();
      test_both_cal();
      test_temp();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
